// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-bank fast-page DRAM sequencer arbitrating video, cpu and CBR refresh
// Optional refresh engine compiled in with `define DRAM_ARBITER_REFRESH_EN
module dram_arbiter #(
    parameter int REF_PERIOD = 437
) (
    input  logic        fclk,
    input  logic        rst,

    input  logic        vid_req,
    input  logic [20:0] vid_addr,
    input  logic        vid_we,
    input  logic [1:0]  vid_be,
    input  logic [15:0] vid_wdata,
    output logic        vid_ack,
    output logic        vid_rvalid,

    input  logic        cpu_req,
    input  logic [20:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_be,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,

    output logic [15:0] rdata,

    output logic        rras0_n,
    output logic        rras1_n,
    output logic        rlcas_n,
    output logic        rucas_n,
    output logic        rwe_n,
    output logic [9:0]  ra,
    output logic [15:0] rd_out,
    output logic        rd_oe,
    input  logic [15:0] rd_in
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RAS     = 3'd1,
        S_CAS1    = 3'd2,
        S_CAS2    = 3'd3,
        S_PRE     = 3'd4,
        S_RF_CAS  = 3'd5,
        S_RF_RAS  = 3'd6,
        S_RF_HOLD = 3'd7
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Transaction latched at grant time; the requester may drop its inputs after ack
    logic        r_owner_vid;
    logic [20:0] r_addr;
    logic        r_we;
    logic [1:0]  r_be;
    logic [15:0] r_wdata;

    logic        w_ref_pend;

`ifdef DRAM_ARBITER_REFRESH_EN
    localparam int             CW     = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(REF_PERIOD - 1);

    logic [CW-1:0] r_ref_cnt;
    logic          r_ref_pend;

    assign w_ref_pend = r_ref_pend;

    // Free-running refresh timer; an expiry while already pending does not queue a second refresh
    always_ff @(posedge fclk) begin
        if (rst) begin
            r_ref_cnt  <= RELOAD;
            r_ref_pend <= 1'b0;
        end else begin
            if (r_ref_cnt == '0) begin
                r_ref_cnt <= RELOAD;
            end else begin
                r_ref_cnt <= r_ref_cnt - 1'b1;
            end
            // A fresh expiry wins over the clear so a request landing on the grant edge is not lost
            if (r_ref_cnt == '0) begin
                r_ref_pend <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_ref_pend <= 1'b0;
            end
        end
    end
`else
    logic [31:0] w_unused_ref_period;

    assign w_ref_pend          = 1'b0;
    assign w_unused_ref_period = 32'(REF_PERIOD);
`endif

    // Arbitration view: in IDLE the winner's live inputs, otherwise the latched transaction
    logic        w_idle;
    logic        w_start;
    logic        w_cur_vid;
    logic [20:0] w_cur_addr;
    logic        w_cur_we;
    logic [1:0]  w_cur_be;
    logic [15:0] w_cur_wdata;

    assign w_idle      = (r_state == S_IDLE);
    assign w_start     = w_idle && !w_ref_pend && (vid_req || cpu_req);
    assign w_cur_vid   = w_idle ? vid_req : r_owner_vid;
    assign w_cur_addr  = w_idle ? (vid_req ? vid_addr  : cpu_addr)  : r_addr;
    assign w_cur_we    = w_idle ? (vid_req ? vid_we    : cpu_we)    : r_we;
    assign w_cur_be    = w_idle ? (vid_req ? vid_be    : cpu_be)    : r_be;
    assign w_cur_wdata = w_idle ? (vid_req ? vid_wdata : cpu_wdata) : r_wdata;

    // Capture the winning request on the grant edge
    always_ff @(posedge fclk) begin
        if (rst) begin
            r_owner_vid <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
        end else if (w_start) begin
            r_owner_vid <= w_cur_vid;
            r_addr      <= w_cur_addr;
            r_we        <= w_cur_we;
            r_be        <= w_cur_be;
            r_wdata     <= w_cur_wdata;
        end
    end

    // State register
    always_ff @(posedge fclk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: refresh beats video beats cpu, decided only in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
`ifdef DRAM_ARBITER_REFRESH_EN
                if (w_ref_pend) begin
                    w_state_next = S_RF_CAS;
                end else
`endif
                if (vid_req || cpu_req) begin
                    w_state_next = S_RAS;
                end
            end
            S_RAS:     w_state_next = S_CAS1;
            S_CAS1:    w_state_next = S_CAS2;
            S_CAS2:    w_state_next = S_PRE;
            S_PRE:     w_state_next = S_IDLE;
`ifdef DRAM_ARBITER_REFRESH_EN
            S_RF_CAS:  w_state_next = S_RF_RAS;
            S_RF_RAS:  w_state_next = S_RF_HOLD;
            S_RF_HOLD: w_state_next = S_PRE;
`endif
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Next values of the registered pins, chosen by the state being entered
    logic        w_nx_ras0_n;
    logic        w_nx_ras1_n;
    logic        w_nx_lcas_n;
    logic        w_nx_ucas_n;
    logic        w_nx_we_n;
    logic [9:0]  w_nx_ra;
    logic [15:0] w_nx_rd_out;
    logic        w_nx_rd_oe;
    logic [15:0] w_nx_rdata;
    logic        w_nx_vid_ack;
    logic        w_nx_cpu_ack;
    logic        w_nx_vid_rvalid;
    logic        w_nx_cpu_rvalid;

    // Output decode: strobes idle high, address/data hold unless a state drives them
    always_comb begin
        w_nx_ras0_n     = 1'b1;
        w_nx_ras1_n     = 1'b1;
        w_nx_lcas_n     = 1'b1;
        w_nx_ucas_n     = 1'b1;
        w_nx_we_n       = 1'b1;
        w_nx_ra         = ra;
        w_nx_rd_out     = rd_out;
        w_nx_rd_oe      = 1'b0;
        w_nx_rdata      = rdata;
        w_nx_vid_ack    = 1'b0;
        w_nx_cpu_ack    = 1'b0;
        w_nx_vid_rvalid = 1'b0;
        w_nx_cpu_rvalid = 1'b0;
        case (w_state_next)
            S_RAS, S_CAS1, S_CAS2: begin
                w_nx_ras0_n = w_cur_addr[20];
                w_nx_ras1_n = !w_cur_addr[20];
                w_nx_rd_oe  = w_cur_we;
                w_nx_we_n   = !w_cur_we;
                if (w_cur_we) begin
                    w_nx_rd_out = w_cur_wdata;
                end
                if (w_state_next == S_RAS) begin
                    w_nx_ra      = w_cur_addr[19:10];
                    w_nx_vid_ack = w_cur_vid;
                    w_nx_cpu_ack = !w_cur_vid;
                end else begin
                    w_nx_ra     = w_cur_addr[9:0];
                    w_nx_lcas_n = !w_cur_be[0];
                    w_nx_ucas_n = !w_cur_be[1];
                end
            end
            S_PRE: begin
                // Only an access (not a refresh) reaches PRE from CAS2
                if (r_state == S_CAS2 && !r_we) begin
                    w_nx_rdata      = rd_in;
                    w_nx_vid_rvalid = r_owner_vid;
                    w_nx_cpu_rvalid = !r_owner_vid;
                end
            end
`ifdef DRAM_ARBITER_REFRESH_EN
            S_RF_CAS: begin
                w_nx_lcas_n = 1'b0;
                w_nx_ucas_n = 1'b0;
            end
            S_RF_RAS, S_RF_HOLD: begin
                w_nx_ras0_n = 1'b0;
                w_nx_ras1_n = 1'b0;
                w_nx_lcas_n = 1'b0;
                w_nx_ucas_n = 1'b0;
            end
`endif
            default: begin
            end
        endcase
    end

    // Pin and handshake registers
    always_ff @(posedge fclk) begin
        if (rst) begin
            rras0_n    <= 1'b1;
            rras1_n    <= 1'b1;
            rlcas_n    <= 1'b1;
            rucas_n    <= 1'b1;
            rwe_n      <= 1'b1;
            ra         <= '0;
            rd_out     <= '0;
            rd_oe      <= 1'b0;
            rdata      <= '0;
            vid_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            vid_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
        end else begin
            rras0_n    <= w_nx_ras0_n;
            rras1_n    <= w_nx_ras1_n;
            rlcas_n    <= w_nx_lcas_n;
            rucas_n    <= w_nx_ucas_n;
            rwe_n      <= w_nx_we_n;
            ra         <= w_nx_ra;
            rd_out     <= w_nx_rd_out;
            rd_oe      <= w_nx_rd_oe;
            rdata      <= w_nx_rdata;
            vid_ack    <= w_nx_vid_ack;
            cpu_ack    <= w_nx_cpu_ack;
            vid_rvalid <= w_nx_vid_rvalid;
            cpu_rvalid <= w_nx_cpu_rvalid;
        end
    end

endmodule
